// File: rtl/gemm_stream_harness.sv
// gemm_stream_harness: streams stored A/B matrix sets into a systolic GEMM
// array, reads the results back and scores them against stored expected C.
//
// state | meaning
// IDLE  | waiting for i_start after reset
// FEED  | streaming N*(N+1) A/B beats for matrix set m
// GAP   | quiet cycles letting the array finish accumulating
// DRAIN | requesting results and comparing each valid beat against C[m]
// DONE  | run finished; status held until the next i_start
module gemm_stream_harness #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DIM        = 4,
  parameter int C_NUM_MAT    = 1,
  parameter int C_GAP        = C_DIM * C_DIM,
  parameter int C_TIMEOUT    = 1024,
  localparam int C_DEPTH     = C_NUM_MAT * C_DIM * C_DIM,
  localparam int C_AW        = $clog2(C_DEPTH)
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_ld_valid,
  input  logic [1:0]              i_ld_sel,
  input  logic [C_AW-1:0]         i_ld_addr,
  input  logic [C_DATA_WIDTH-1:0] i_ld_data,
  input  logic                    i_start,
  output logic [C_DATA_WIDTH-1:0] o_Ain_data,
  output logic [C_DATA_WIDTH-1:0] o_Bin_data,
  output logic                    o_in_valid,
  output logic                    o_rd_output,
  input  logic [C_DATA_WIDTH-1:0] i_Cout_data,
  input  logic                    i_Cout_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [15:0]             o_err_count,
  output logic [C_AW:0]           o_err_index
);

  localparam int C_NN       = C_DIM * C_DIM;
  localparam int C_FEED_LEN = C_DIM * (C_DIM + 1);
  localparam int C_BW       = $clog2(C_FEED_LEN);
  localparam int C_KW       = $clog2(C_NN);
  localparam int C_MW       = (C_NUM_MAT > 1) ? $clog2(C_NUM_MAT) : 1;
  localparam int C_GW       = $clog2(C_GAP + 2);
  localparam int C_TW       = $clog2(C_TIMEOUT + 1);
  localparam int C_EW       = C_AW + 1;

  localparam logic [C_BW-1:0] C_BEAT_LAST = C_BW'(C_FEED_LEN - 1);
  localparam logic [C_BW-1:0] C_DIM_B     = C_BW'(C_DIM);
  localparam logic [C_BW-1:0] C_NN_B      = C_BW'(C_NN);
  localparam logic [C_KW-1:0] C_K_LAST    = C_KW'(C_NN - 1);
  localparam logic [C_MW-1:0] C_M_LAST    = C_MW'(C_NUM_MAT - 1);
  localparam logic [C_GW-1:0] C_GAP_LOAD  = C_GW'((C_GAP > 0) ? C_GAP - 1 : 0);
  localparam logic [C_TW-1:0] C_TMO_LOAD  = C_TW'(C_TIMEOUT);
  localparam logic [C_TW-1:0] C_TMO_ONE   = C_TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } t_state;

  t_state                  r_state;
  t_state                  w_state_nxt;
  logic [C_BW-1:0]         r_beat, w_beat_nxt;
  logic [C_GW-1:0]         r_gap, w_gap_nxt;
  logic [C_KW-1:0]         r_k, w_k_nxt;
  logic [C_TW-1:0]         r_tmo, w_tmo_nxt;
  logic [C_MW-1:0]         r_m, w_m_nxt;
  logic                    r_timeout, w_timeout_nxt;
  logic [15:0]             r_err_count, w_err_count_nxt, w_cnt_base;
  logic [C_EW-1:0]         r_err_index, w_err_index_nxt, w_idx_base;
  logic                    w_mismatch;
  logic [C_EW-1:0]         w_mis_idx;

  logic [C_DATA_WIDTH-1:0] r_mem_a [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] r_mem_b [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] r_mem_c [C_DEPTH];

  logic                    w_ld_en;
  logic [C_AW-1:0]         w_a_addr, w_b_addr, w_c_addr;
  logic [C_DATA_WIDTH-1:0] w_a_rd, w_b_rd, w_a_nxt, w_b_nxt;

  logic [C_DATA_WIDTH-1:0] r_ain, r_bin;
  logic                    r_in_valid, r_rd_output, r_busy, r_done, r_pass;

  // flat row-major, matrix-major address of element 'off' within set m
  function automatic logic [C_AW-1:0] f_addr(input logic [C_MW-1:0] m, input int off);
    f_addr = C_AW'(int'(m) * C_NN + off);
  endfunction

  assign w_ld_en  = i_ld_valid && !r_busy;
  assign w_c_addr = f_addr(r_m, int'(r_k));

  // pattern memories: plain register file, never cleared by reset
  always_ff @(posedge clock) begin
    if (w_ld_en) begin
      case (i_ld_sel)
        2'd0:    r_mem_a[i_ld_addr] <= i_ld_data;
        2'd1:    r_mem_b[i_ld_addr] <= i_ld_data;
        2'd2:    r_mem_c[i_ld_addr] <= i_ld_data;
        default: ;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state, counter and scoring decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_gap_nxt     = r_gap;
    w_k_nxt       = r_k;
    w_tmo_nxt     = r_tmo;
    w_m_nxt       = r_m;
    w_timeout_nxt = r_timeout;
    w_cnt_base    = r_err_count;
    w_idx_base    = r_err_index;
    w_mismatch    = 1'b0;
    w_mis_idx     = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt   = S_FEED;
          w_beat_nxt    = '0;
          w_m_nxt       = '0;
          w_k_nxt       = '0;
          w_cnt_base    = '0;
          w_idx_base    = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_FEED: begin
        if (r_beat == C_BEAT_LAST) begin
          if (C_GAP == 0) begin
            w_state_nxt = S_DRAIN;
            w_k_nxt     = '0;
            w_tmo_nxt   = C_TMO_LOAD;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = C_GAP_LOAD;
          end
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = S_DRAIN;
          w_k_nxt     = '0;
          w_tmo_nxt   = C_TMO_LOAD;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_Cout_valid) begin
          w_mismatch = (i_Cout_data != r_mem_c[w_c_addr]);
          w_mis_idx  = C_EW'(int'(r_m) * C_NN + int'(r_k));
          w_tmo_nxt  = C_TMO_LOAD;
          if (r_k == C_K_LAST) begin
            w_k_nxt = '0;
            if (r_m != C_M_LAST) begin
              w_m_nxt     = r_m + 1'b1;
              w_state_nxt = S_FEED;
              w_beat_nxt  = '0;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end else if (r_tmo <= C_TMO_ONE) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_tmo_nxt = r_tmo - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // a result beat the harness did not ask for is always an error
    if (i_Cout_valid && (r_state != S_DRAIN)) begin
      w_mismatch = 1'b1;
      w_mis_idx  = '1;
    end

    w_err_count_nxt = w_cnt_base;
    w_err_index_nxt = w_idx_base;
    if (w_mismatch) begin
      if (w_cnt_base == '0)      w_err_index_nxt = w_mis_idx;
      if (w_cnt_base != 16'hFFFF) w_err_count_nxt = w_cnt_base + 16'd1;
    end
  end

  // stream data for the beat about to be presented; a load in the start
  // cycle is forwarded so the very first beat already sees the new value
  always_comb begin
    w_a_addr = f_addr(w_m_nxt, int'(w_beat_nxt) - C_DIM);
    w_b_addr = f_addr(w_m_nxt, int'(w_beat_nxt));
    w_a_rd   = (w_ld_en && (i_ld_sel == 2'd0) && (i_ld_addr == w_a_addr)) ?
               i_ld_data : r_mem_a[w_a_addr];
    w_b_rd   = (w_ld_en && (i_ld_sel == 2'd1) && (i_ld_addr == w_b_addr)) ?
               i_ld_data : r_mem_b[w_b_addr];
    w_a_nxt  = '0;
    w_b_nxt  = '0;
    if (w_state_nxt == S_FEED) begin
      if (w_beat_nxt >= C_DIM_B) w_a_nxt = w_a_rd;
      if (w_beat_nxt <  C_NN_B)  w_b_nxt = w_b_rd;
    end
  end

  // counters and registered outputs, all derived from next-state values
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_beat      <= '0;
      r_gap       <= '0;
      r_k         <= '0;
      r_tmo       <= '0;
      r_m         <= '0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
      r_err_index <= '0;
      r_ain       <= '0;
      r_bin       <= '0;
      r_in_valid  <= 1'b0;
      r_rd_output <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_beat      <= w_beat_nxt;
      r_gap       <= w_gap_nxt;
      r_k         <= w_k_nxt;
      r_tmo       <= w_tmo_nxt;
      r_m         <= w_m_nxt;
      r_timeout   <= w_timeout_nxt;
      r_err_count <= w_err_count_nxt;
      r_err_index <= w_err_index_nxt;
      r_ain       <= w_a_nxt;
      r_bin       <= w_b_nxt;
      r_in_valid  <= (w_state_nxt == S_FEED);
      r_rd_output <= (w_state_nxt == S_DRAIN);
      r_busy      <= (w_state_nxt == S_FEED) || (w_state_nxt == S_GAP) ||
                     (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_DONE);
      r_pass      <= (w_state_nxt == S_DONE) && (w_err_count_nxt == '0) &&
                     !w_timeout_nxt;
    end
  end

  assign o_Ain_data  = r_ain;
  assign o_Bin_data  = r_bin;
  assign o_in_valid  = r_in_valid;
  assign o_rd_output = r_rd_output;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_err_count = r_err_count;
  assign o_err_index = r_err_index;

endmodule

// File: tb/tb_gemm_stream_harness.sv
// Bench for gemm_stream_harness: the bench plays the systolic array, returning
// stored expected results on request, and scores status against a table.
module tb_gemm_stream_harness;

  localparam int N   = 4;
  localparam int NN  = 16;
  localparam int NM  = 2;
  localparam int DW  = 32;
  localparam int GAP = 16;
  localparam int TMO = 8;
  localparam int AW  = 5;

  logic          clock = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [1:0]    ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic [DW-1:0] ain, bin;
  logic          in_valid, rd_output;
  logic [DW-1:0] cout_data;
  logic          cout_valid;
  logic          busy, done, pass, tmo;
  logic [15:0]   err_count;
  logic [AW:0]   err_index;

  always #5 clock = ~clock;

  gemm_stream_harness #(
    .C_DATA_WIDTH(DW), .C_DIM(N), .C_NUM_MAT(NM), .C_GAP(GAP), .C_TIMEOUT(TMO)
  ) u_dut (
    .clock(clock), .i_reset(rst),
    .i_ld_valid(ld_valid), .i_ld_sel(ld_sel), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_start(start),
    .o_Ain_data(ain), .o_Bin_data(bin), .o_in_valid(in_valid), .o_rd_output(rd_output),
    .i_Cout_data(cout_data), .i_Cout_valid(cout_valid),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
    .o_err_count(err_count), .o_err_index(err_index)
  );

  typedef struct {
    int bad_set; int bad_k; int bad_all; int beats0; int spur; int ldst;
    int exp_pass; int exp_cnt; int exp_idx; int exp_tmo; int exp_sets; int exp_idle;
  } vec_t;

  vec_t vt[7];
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] ma[NM*NN];
  logic [DW-1:0] mb[NM*NN];
  logic [DW-1:0] mc[NM*NN];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input int a, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_sel = s; ld_addr = AW'(a); ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic run(input vec_t v, input int id);
    int bm = 0, bk = 0, fb = 0, cyc = 0;
    int nfeed = 0, ngap = 0, nidle = 0, feed_bad = 0, between_bad = 0;
    bit sw = 0, drove = 0;
    logic [DW-1:0] ea, eb;
    if (v.ldst != 0) begin
      mb[0] = 32'h777 + DW'(id);
      ld_valid = 1'b1; ld_sel = 2'd1; ld_addr = '0; ld_data = mb[0];
    end
    start = 1'b1;
    tick();
    start = 1'b0; ld_valid = 1'b0;
    while (done !== 1'b1 && cyc < 600) begin
      if (in_valid === 1'b1) begin
        if (fb >= N*(N+1) || bm >= NM) feed_bad++;
        else begin
          if (fb < N) ea = '0; else ea = ma[bm*NN + fb - N];
          if (fb < NN) eb = mb[bm*NN + fb]; else eb = '0;
          if (ain !== ea || bin !== eb) feed_bad++;
        end
        fb++; nfeed++;
      end else if (busy === 1'b1 && rd_output === 1'b0) begin
        ngap++;
      end
      if (sw) begin
        if (rd_output !== 1'b0 || in_valid !== 1'b1) between_bad++;
        sw = 0;
      end
      drove = 0; cout_valid = 1'b0; cout_data = '0; ld_valid = 1'b0;
      if (rd_output === 1'b1) begin
        if (bm == 0 && bk >= v.beats0) nidle++;
        else if (bm < NM) begin
          drove = 1; cout_valid = 1'b1;
          cout_data = mc[bm*NN + bk] ^
            (((v.bad_all != 0) || (bm == v.bad_set && bk == v.bad_k)) ? 32'h1 : 32'h0);
        end
      end
      if (v.spur != 0 && cyc == 2) begin
        cout_valid = 1'b1; cout_data = 32'hBAD0;
        ld_valid = 1'b1; ld_sel = 2'd1; ld_addr = 5'd16; ld_data = 32'hDEAD_BEEF;
      end
      start = (v.spur != 0 && cyc == 25);
      tick();
      cyc++;
      if (drove) begin
        bk++;
        if (bk == NN) begin bk = 0; bm++; fb = 0; sw = (bm < NM); end
      end
    end
    cout_valid = 1'b0; ld_valid = 1'b0; start = 1'b0;
    chk($sformatf("v%0d_done", id), done, 1);
    chk($sformatf("v%0d_busy", id), busy, 0);
    chk($sformatf("v%0d_pass", id), pass, v.exp_pass);
    chk($sformatf("v%0d_err_count", id), err_count, v.exp_cnt);
    chk($sformatf("v%0d_err_index", id), err_index, v.exp_idx);
    chk($sformatf("v%0d_timeout", id), tmo, v.exp_tmo);
    chk($sformatf("v%0d_feed_beats", id), nfeed, 20 * v.exp_sets);
    chk($sformatf("v%0d_gap_cycles", id), ngap, GAP * v.exp_sets);
    chk($sformatf("v%0d_drain_idle", id), nidle, v.exp_idle);
    chk($sformatf("v%0d_feed_data_bad", id), feed_bad, 0);
    chk($sformatf("v%0d_between_sets_bad", id), between_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //          bad_set bad_k all beats0 spur ldst | pass cnt idx tmo sets idle
    vt[0] = '{-1, -1, 0, 16, 0, 0,  1,  0,  0, 0, 2, 0};
    vt[1] = '{ 0,  5, 0, 16, 0, 0,  0,  1,  5, 0, 2, 0};
    vt[2] = '{ 1,  3, 0, 16, 0, 0,  0,  1, 19, 0, 2, 0};
    vt[3] = '{-1, -1, 0, 10, 0, 0,  0,  0,  0, 1, 1, 8};
    vt[4] = '{-1, -1, 1, 16, 0, 0,  0, 32,  0, 0, 2, 0};
    vt[5] = '{-1, -1, 0, 16, 1, 0,  0,  1, 63, 0, 2, 0};
    vt[6] = '{-1, -1, 0, 16, 0, 1,  1,  0,  0, 0, 2, 0};

    rst = 1'b1; ld_valid = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    start = 1'b0; cout_data = '0; cout_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {busy, done, pass, tmo, in_valid, rd_output, err_count, err_index, ain, bin}, '0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", {busy, done, pass, tmo, in_valid, rd_output, err_count, err_index, ain, bin}, '0);

    for (int i = 0; i < NM*NN; i++) begin
      ma[i] = (((i % NN) / N) == ((i % NN) % N)) ? 32'd1 : 32'd0;
      mb[i] = (i < NN) ? DW'(i + 1) : DW'(100 + i);
      mc[i] = mb[i];
      load(2'd0, i, ma[i]);
      load(2'd1, i, mb[i]);
      load(2'd2, i, mc[i]);
    end
    load(2'd3, 0, 32'hFFFF_FFFF);

    for (int i = 0; i < 7; i++) run(vt[i], i);

    // reset while the harness sits in GAP, then a clean re-run
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (busy === 1'b1 && in_valid === 1'b0 && rd_output === 1'b0) found = 1;
      else tick();
    end
    chk("gap_reached", found, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("reset_in_gap", {busy, done, pass, tmo, in_valid, rd_output, err_count, err_index, ain, bin}, '0);
    #1;
    rst = 1'b0;
    tick();
    run(vt[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
